// File: rtl/bus_slave_port.sv
// Purpose: serial-bus slave endpoint; deserialises address/write data into a local word memory, serialises read data back.
// Latency: write lands 1 cycle after its last data bit; first read bit READ_LATENCY+1 cycles after the last address bit.
// Backpressure: address/data bits advance only on valid & bus_ready; read data never stalls, hold covers read latency.
//
// Ports:
//   clk, reset          bus clock (rising edge), asynchronous active-high reset
//   address, data       serial address / write-data bits, MSB first
//   valid, bus_ready    bit qualifier; a bit is taken only when both are high
//   write_en            1=write, 0=read, taken with the first address bit
//   burst               continue at address+1, taken with the last data bit of each word
//   data_out, valid_out serial read data and its qualifier
//   ready               high only while idle
//   hold                high while read latency is in progress
module bus_slave_port #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic address,
  input  logic data,
  input  logic valid,
  input  logic write_en,
  input  logic burst,
  input  logic bus_ready,
  output logic data_out,
  output logic valid_out,
  output logic ready,
  output logic hold
);

  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [3:0]    LAT_LAST  = (READ_LATENCY == 0) ? 4'd0 : 4'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RLAT, S_RDATA
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr, addr_n;
  logic [CW-1:0]           bit_cnt, bit_cnt_n;
  logic [3:0]              lat_cnt, lat_cnt_n;
  logic                    we_r, we_n;
  logic                    burst_r, burst_n;
  logic [DATA_WIDTH-1:0]   sh, sh_n;     // write-data deserialiser, reused as read-data serialiser
  logic                    data_out_n;

  logic [DATA_WIDTH-1:0]   mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0]   addr_shift, addr_inc, rd_addr;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    acc;

  assign acc        = valid & bus_ready;
  assign addr_shift = {addr[ADDR_WIDTH-2:0], address};
  assign addr_inc   = addr + ADDR_WIDTH'(1);   // wraps all-ones -> 0 naturally

  // The word to load is fetched from the address the register will hold
  // next: the just-completed address (zero latency), or addr+1 on a
  // zero-latency burst continuation.
  always_comb begin
    rd_addr = addr;
    case (state)
      S_ADDR:  rd_addr = addr_shift;
      S_RDATA: rd_addr = addr_inc;
      default: rd_addr = addr;
    endcase
  end

  assign rd_word = mem[rd_addr];

  always_comb begin
    state_n   = state;
    addr_n    = addr;
    bit_cnt_n = bit_cnt;
    lat_cnt_n = lat_cnt;
    we_n      = we_r;
    burst_n   = burst_r;
    sh_n      = sh;
    case (state)
      S_IDLE: begin
        if (acc) begin
          addr_n    = {{(ADDR_WIDTH-1){1'b0}}, address};
          we_n      = write_en;
          bit_cnt_n = CW'(1);
          state_n   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (acc) begin
          addr_n = addr_shift;
          if (bit_cnt == ADDR_LAST) begin
            bit_cnt_n = '0;
            if (we_r) begin
              state_n = S_WDATA;
            end else if (READ_LATENCY == 0) begin
              sh_n    = rd_word;
              state_n = S_RDATA;
            end else begin
              lat_cnt_n = '0;
              state_n   = S_RLAT;
            end
          end else begin
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      S_WDATA: begin
        if (acc) begin
          sh_n = {sh[DATA_WIDTH-2:0], data};
          if (bit_cnt == DATA_LAST) begin
            bit_cnt_n = '0;
            burst_n   = burst;
            state_n   = S_WRITE;
          end else begin
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      S_WRITE: begin
        if (burst_r) begin
          addr_n  = addr_inc;
          state_n = S_WDATA;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_RLAT: begin
        if (lat_cnt == LAT_LAST) begin
          sh_n    = rd_word;
          state_n = S_RDATA;
        end else begin
          lat_cnt_n = lat_cnt + 4'd1;
        end
      end
      S_RDATA: begin
        sh_n = {sh[DATA_WIDTH-2:0], 1'b0};
        if (bit_cnt == DATA_LAST) begin
          bit_cnt_n = '0;
          if (burst) begin
            addr_n = addr_inc;
            if (READ_LATENCY == 0) begin
              sh_n    = rd_word;
              state_n = S_RDATA;
            end else begin
              lat_cnt_n = '0;
              state_n   = S_RLAT;
            end
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    // The serialiser MSB always holds the bit to present next cycle.
    data_out_n = (state_n == S_RDATA) ? sh_n[DATA_WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      bit_cnt   <= '0;
      lat_cnt   <= '0;
      we_r      <= 1'b0;
      burst_r   <= 1'b0;
      sh        <= '0;
      data_out  <= 1'b0;
      valid_out <= 1'b0;
      ready     <= 1'b1;
      hold      <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      bit_cnt   <= bit_cnt_n;
      lat_cnt   <= lat_cnt_n;
      we_r      <= we_n;
      burst_r   <= burst_n;
      sh        <= sh_n;
      data_out  <= data_out_n;
      valid_out <= (state_n == S_RDATA);
      ready     <= (state_n == S_IDLE);
      hold      <= (state_n == S_RLAT);
    end
  end

  // Memory is deliberately not reset; only a completed word reaches it.
  always_ff @(posedge clk) begin
    if (state == S_WRITE) begin
      mem[addr] <= sh;
    end
  end

endmodule

// File: tb/tb_bus_slave_port.sv
// Purpose: directed + randomized bench for bus_slave_port against a word-array reference model.
// Latency: reads expect RL hold cycles then DW data bits; writes expect one busy cycle after the last bit.
// Backpressure: random valid/bus_ready gaps are inserted in address and write-data phases.
module tb_bus_slave_port;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic reset, address, data, valid, write_en, burst, bus_ready;
  logic data_out, valid_out, ready, hold;

  int n_checks = 0;
  int n_fails  = 0;
  bit rand_gap = 1'b0;

  logic [DW-1:0] model [0:(1<<AW)-1];
  logic [DW-1:0] wq [$];
  logic [DW-1:0] rq [$];

  bus_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset), .address(address), .data(data), .valid(valid),
    .write_en(write_en), .burst(burst), .bus_ready(bus_ready),
    .data_out(data_out), .valid_out(valid_out), .ready(ready), .hold(hold)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles that must not be accepted: either valid low, or bus taken away with valid noise.
  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        valid = 1'b0; bus_ready = 1'b1;
      end else begin
        bus_ready = 1'b0; valid = 1'($urandom);
      end
      address  = 1'($urandom);
      data     = 1'($urandom);
      write_en = 1'($urandom);
      tick();
    end
    valid = 1'b0; bus_ready = 1'b1;
  endtask

  task automatic maybe_gap;
    if (rand_gap && $urandom_range(0, 3) == 0) gap($urandom_range(1, 2));
  endtask

  task automatic send_addr(input logic [AW-1:0] a, input logic we, input int stall_at, input int stall_len);
    for (int i = 0; i < AW; i++) begin
      if (i == stall_at) gap(stall_len);
      maybe_gap();
      address = a[AW-1-i]; write_en = we; valid = 1'b1; bus_ready = 1'b1; data = 1'($urandom);
      tick();
      if (i == 0) check("ready_fall", ready, 0);
    end
    valid = 1'b0;
  endtask

  // Writes the words queued in wq starting at a (burst if more than one).
  task automatic write_txn(input logic [AW-1:0] a, input int stall_at, input int stall_len);
    logic [AW-1:0] wa;
    wa = a;
    send_addr(a, 1'b1, stall_at, stall_len);
    for (int w = 0; w < wq.size(); w++) begin
      for (int b = 0; b < DW; b++) begin
        maybe_gap();
        data = wq[w][DW-1-b]; burst = (w < wq.size() - 1);
        valid = 1'b1; bus_ready = 1'b1; address = 1'($urandom);
        tick();
      end
      valid = 1'b0; burst = 1'b0;
      check("write_cycle_flags", {ready, valid_out, hold}, 3'b000);
      tick();
      model[wa] = wq[w];
      wa = wa + AW'(1);
      if (w < wq.size() - 1) check("burst_write_busy", ready, 0);
    end
    check("write_done_ready", {ready, valid_out, hold}, 3'b100);
  endtask

  // Reads n words from a; each bit is compared against the model, words land in rq.
  task automatic read_txn(input logic [AW-1:0] a, input int n, input int stall_at, input int stall_len);
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_w, got_w;
    ra = a;
    rq.delete();
    send_addr(a, 1'b0, stall_at, stall_len);
    for (int w = 0; w < n; w++) begin
      burst = (w < n - 1);
      for (int k = 0; k < RL; k++) begin
        check("rlat_flags", {ready, valid_out, hold, data_out}, 4'b0010);
        tick();
      end
      exp_w = model[ra];
      got_w = '0;
      for (int b = 0; b < DW; b++) begin
        check("rdata_flags", {ready, valid_out, hold}, 3'b010);
        check("rdata_bit", data_out, exp_w[DW-1-b]);
        got_w = {got_w[DW-2:0], data_out};
        tick();
      end
      rq.push_back(got_w);
      ra = ra + AW'(1);
    end
    burst = 1'b0;
    check("read_end_flags", {ready, valid_out, hold, data_out}, 4'b1000);
  endtask

  initial begin
    logic [DW-1:0] w0, w1;
    logic [AW-1:0] sa;
    int n;

    reset = 1'b1; valid = 1'b0; bus_ready = 1'b1; address = 1'b0; data = 1'b0;
    write_en = 1'b0; burst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", {ready, valid_out, hold, data_out}, 4'b1000);
    reset = 1'b0;
    tick();
    check("idle_after_reset", {ready, valid_out, hold, data_out}, 4'b1000);

    // Basic write then read.
    wq.delete(); wq.push_back(8'hA5);
    write_txn(12'h123, -1, 0);
    read_txn(12'h123, 1, -1, 0);
    check("read_123", rq[0], 8'hA5);

    // Burst write across the top of the address space.
    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
    write_txn(12'hFFF, -1, 0);
    read_txn(12'hFFF, 1, -1, 0);
    check("read_fff", rq[0], 8'h11);
    read_txn(12'h000, 1, -1, 0);
    check("read_000_wrap", rq[0], 8'h22);
    read_txn(12'hFFF, 2, -1, 0);
    check("burst_read_wrap_0", rq[0], 8'h11);
    check("burst_read_wrap_1", rq[1], 8'h22);

    // Stalls in the address phase must not capture extra bits.
    wq.delete(); wq.push_back(8'h5A);
    write_txn(12'h345, 5, 3);
    read_txn(12'h345, 1, -1, 0);
    check("stalled_write", rq[0], 8'h5A);
    read_txn(12'h345, 1, 5, 3);
    check("stalled_read", rq[0], 8'h5A);
    read_txn(12'h123, 1, 5, 3);
    check("stalled_read_123", rq[0], 8'hA5);

    // Bus granted elsewhere: valid toggling must be ignored.
    for (int i = 0; i < 20; i++) begin
      bus_ready = 1'b0; valid = i[0]; address = 1'($urandom); write_en = 1'($urandom);
      data = 1'($urandom);
      tick();
      check("bus_not_ready_idle", {ready, valid_out, hold}, 3'b100);
    end
    bus_ready = 1'b1; valid = 1'b0;
    read_txn(12'h123, 1, -1, 0);
    check("mem_kept_123", rq[0], 8'hA5);
    read_txn(12'hFFF, 1, -1, 0);
    check("mem_kept_fff", rq[0], 8'h11);

    // Reset in the middle of a write leaves the old word intact.
    wq.delete(); wq.push_back(8'h3C);
    write_txn(12'h010, -1, 0);
    send_addr(12'h010, 1'b1, -1, 0);
    for (int b = 0; b < 4; b++) begin
      data = 1'b1; valid = 1'b1; bus_ready = 1'b1;
      tick();
    end
    valid = 1'b1;
    reset = 1'b1;
    #2;
    check("mid_reset_flags", {ready, valid_out, hold}, 3'b100);
    @(posedge clk);
    #1;
    reset = 1'b0; valid = 1'b0;
    tick();
    check("post_reset_idle", {ready, valid_out, hold}, 3'b100);
    read_txn(12'h010, 1, -1, 0);
    check("aborted_write", rq[0], 8'h3C);

    // Burst read of two fresh words.
    w0 = 8'($urandom); w1 = 8'($urandom);
    wq.delete(); wq.push_back(w0); wq.push_back(w1);
    write_txn(12'h020, -1, 0);
    read_txn(12'h020, 2, -1, 0);
    check("burst_read_020", rq[0], w0);
    check("burst_read_021", rq[1], w1);

    // Randomized traffic over a preloaded window, with random stalls.
    rand_gap = 1'b1;
    wq.delete();
    for (int i = 0; i < 16; i++) wq.push_back(8'($urandom));
    write_txn(12'h200, -1, 0);
    for (int t = 0; t < 25; t++) begin
      sa = 12'h200 + AW'($urandom_range(0, 12));
      n  = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
        write_txn(sa, -1, 0);
      end else begin
        read_txn(sa, n, -1, 0);
      end
    end
    rand_gap = 1'b0;
    read_txn(12'h200, 3, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
